// File: rtl/conv_stream_multi_k.sv
// rtl/conv_stream_multi_k.sv - streaming KxK convolution, NUM_K kernels per window
module conv_stream_multi_k #(
  parameter  int DATA_W     = 8,
  parameter  int IMG_WIDTH  = 3,
  parameter  int IMG_HEIGHT = 3,
  parameter  int KSIZE      = 2,
  parameter  int NUM_K      = 2,
  localparam int ACC_W      = 2*DATA_W + $clog2(KSIZE*KSIZE),
  localparam int ROW_W      = $clog2(IMG_HEIGHT),
  localparam int COL_W      = $clog2(IMG_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_valid,
  input  logic [DATA_W-1:0]      w_data,
  output logic                   w_ready,
  input  logic                   reload,
  input  logic                   pix_valid,
  input  logic [DATA_W-1:0]      pix_data,
  output logic                   pix_ready,
  output logic                   out_valid,
  output logic [NUM_K*ACC_W-1:0] out_data,
  output logic [ROW_W-1:0]       out_row,
  output logic [COL_W-1:0]       out_col,
  output logic                   frame_done
);
  localparam int KK     = KSIZE*KSIZE;
  localparam int NSLOT  = NUM_K*KK;
  localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int PROD_W = 2*DATA_W;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NSLOT-1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT-1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH-1);
  localparam logic [ROW_W-1:0]  ROW_OFS   = ROW_W'(KSIZE-1);
  localparam logic [COL_W-1:0]  COL_OFS   = COL_W'(KSIZE-1);

  typedef enum logic {LOAD, STREAM} state_e;

  state_e                 state_q, state_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [DATA_W-1:0]      w_q [NSLOT];
  logic [ROW_W-1:0]       row_q;
  logic [COL_W-1:0]       col_q;
  logic [DATA_W-1:0]      lb_q [KSIZE-1][IMG_WIDTH];
  logic [DATA_W-1:0]      win_q [KSIZE][KSIZE];
  logic                   v0_q, last0_q;
  logic [ROW_W-1:0]       row0_q;
  logic [COL_W-1:0]       col0_q;
  logic                   v1_q, last1_q;
  logic [ROW_W-1:0]       row1_q;
  logic [COL_W-1:0]       col1_q;
  logic [PROD_W-1:0]      prod_q [NSLOT];
  logic [ACC_W-1:0]       sum_d [NUM_K];
  logic                   out_valid_q, frame_done_q;
  logic [NUM_K*ACC_W-1:0] out_data_q;
  logic [ROW_W-1:0]       out_row_q;
  logic [COL_W-1:0]       out_col_q;
  logic                   w_fire, pix_fire, reload_ok, win_ok;

  // Reload only at a frame boundary with nothing in flight, so weights never change under live data
  assign reload_ok = (state_q == STREAM) && reload && (row_q == '0) && (col_q == '0)
                     && !v0_q && !v1_q && !out_valid_q;
  assign w_ready   = (state_q == LOAD);
  assign pix_ready = (state_q == STREAM) && !reload_ok;
  assign w_fire    = w_valid && w_ready;
  assign pix_fire  = pix_valid && pix_ready;
  assign win_ok    = (row_q >= ROW_OFS) && (col_q >= COL_OFS);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      LOAD: begin
        if (w_fire) begin
          if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            state_d = STREAM;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (reload_ok) begin
          slot_d  = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      slot_q  <= '0;
      for (int i = 0; i < NSLOT; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      if (w_fire) w_q[slot_q] <= w_data;
    end
  end

  // Line buffer j holds, per column, the pixel from j+1 rows above the current one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q   <= '0;
      col_q   <= '0;
      v0_q    <= 1'b0;
      last0_q <= 1'b0;
      row0_q  <= '0;
      col0_q  <= '0;
      for (int j = 0; j < KSIZE-1; j++)
        for (int x = 0; x < IMG_WIDTH; x++) lb_q[j][x] <= '0;
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++) win_q[r][c] <= '0;
    end else begin
      v0_q <= pix_fire && win_ok;
      if (pix_fire) begin
        last0_q <= (row_q == ROW_LAST) && (col_q == COL_LAST);
        row0_q  <= row_q - ROW_OFS;
        col0_q  <= col_q - COL_OFS;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        lb_q[0][col_q] <= pix_data;
        for (int j = 1; j < KSIZE-1; j++) lb_q[j][col_q] <= lb_q[j-1][col_q];
        for (int r = 0; r < KSIZE; r++)
          for (int c = 0; c < KSIZE-1; c++) win_q[r][c] <= win_q[r][c+1];
        for (int r = 0; r < KSIZE-1; r++) win_q[r][KSIZE-1] <= lb_q[KSIZE-2-r][col_q];
        win_q[KSIZE-1][KSIZE-1] <= pix_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      row1_q  <= '0;
      col1_q  <= '0;
      for (int i = 0; i < NSLOT; i++) prod_q[i] <= '0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        last1_q <= last0_q;
        row1_q  <= row0_q;
        col1_q  <= col0_q;
        for (int k = 0; k < NUM_K; k++)
          for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++)
              prod_q[k*KK + r*KSIZE + c] <= PROD_W'(w_q[k*KK + r*KSIZE + c]) * PROD_W'(win_q[r][c]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_K; k++) begin
      sum_d[k] = '0;
      for (int t = 0; t < KK; t++) sum_d[k] = sum_d[k] + ACC_W'(prod_q[k*KK + t]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      out_valid_q  <= v1_q;
      frame_done_q <= v1_q && last1_q;
      if (v1_q) begin
        out_row_q <= row1_q;
        out_col_q <= col1_q;
        for (int k = 0; k < NUM_K; k++) out_data_q[k*ACC_W +: ACC_W] <= sum_d[k];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_data   = out_data_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
endmodule

// File: tb/tb_conv_stream_multi_k.sv
// tb/tb_conv_stream_multi_k.sv - self-checking bench for conv_stream_multi_k
module tb_conv_stream_multi_k;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 3;
  localparam int IMG_H  = 3;
  localparam int K      = 2;
  localparam int NK     = 2;
  localparam int KK     = K*K;
  localparam int NSLOT  = NK*KK;
  localparam int ACC_W  = 2*DATA_W + $clog2(KK);
  localparam int RW     = $clog2(IMG_H);
  localparam int CW     = $clog2(IMG_W);
  localparam int OW     = NK*ACC_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              w_valid = 1'b0;
  logic              reload = 1'b0;
  logic              pix_valid = 1'b0;
  logic [DATA_W-1:0] w_data = '0;
  logic [DATA_W-1:0] pix_data = '0;
  logic              w_ready, pix_ready, out_valid, frame_done;
  logic [OW-1:0]     out_data;
  logic [RW-1:0]     out_row;
  logic [CW-1:0]     out_col;

  conv_stream_multi_k #(.DATA_W(DATA_W), .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H),
                        .KSIZE(K), .NUM_K(NK)) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .reload(reload), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          fd;
    logic [31:0]   cyc;
  } res_t;

  res_t        obs_q[$];
  res_t        exp_q[$];
  int unsigned cyc = 0;
  int          nvec = 0;
  int          nfail = 0;
  int          stray_fd = 0;
  int          wsrc[NSLOT];
  int          mw[NSLOT];
  int          pix_src[$];
  int          img[IMG_H][IMG_W];
  int          mrow = 0;
  int          mcol = 0;
  int          ref0[4];
  int          ref1[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    res_t r;
    if (out_valid === 1'b1) begin
      r.data = out_data; r.row = out_row; r.col = out_col; r.fd = frame_done; r.cyc = cyc;
      obs_q.push_back(r);
    end
    if (frame_done === 1'b1 && out_valid !== 1'b1) stray_fd++;
  end

  // Reference: window of the current frame image times weights, output due 2 edges after the pixel edge
  task automatic model_accept(input int p);
    res_t   e;
    longint s;
    img[mrow][mcol] = p;
    if (mrow >= K-1 && mcol >= K-1) begin
      e = '0;
      for (int k = 0; k < NK; k++) begin
        s = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            s += longint'(mw[k*KK + r*K + c]) * img[mrow-K+1+r][mcol-K+1+c];
        e.data[k*ACC_W +: ACC_W] = s[ACC_W-1:0];
      end
      e.row = RW'(mrow-K+1);
      e.col = CW'(mcol-K+1);
      e.fd  = (mrow == IMG_H-1) && (mcol == IMG_W-1);
      e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    if (mcol == IMG_W-1) begin
      mcol = 0;
      mrow = (mrow == IMG_H-1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  task automatic load_weights(input bit gaps, output bit ok, output logic pr, output logic wr);
    int idx = 0;
    int budget = 400;
    bit v;
    while (idx < NSLOT && budget > 0) begin
      @(negedge clk);
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      w_valid = v;
      w_data = DATA_W'(wsrc[idx]);
      #1;
      if (v && w_ready === 1'b1) begin
        mw[idx] = wsrc[idx];
        idx++;
      end
      budget--;
    end
    @(negedge clk);
    w_valid = 1'b0;
    #1;
    pr = pix_ready;
    wr = w_ready;
    ok = (idx == NSLOT);
  endtask

  task automatic send(input int gap_mode, input int hold_from, input int hold_to, output bit ok);
    int idx = 0;
    int budget = 2000;
    bit v;
    while (idx < pix_src.size() && budget > 0) begin
      @(negedge clk);
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      pix_valid = v;
      pix_data = DATA_W'(pix_src[idx]);
      reload = (idx >= hold_from) && (idx < hold_to);
      #1;
      if (v && pix_ready === 1'b1) begin
        model_accept(pix_src[idx]);
        idx++;
      end
      budget--;
    end
    ok = (idx == pix_src.size());
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    pix_valid = 1'b0;
    reload = 1'b0;
    w_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic request_reload(output bit ok);
    int budget = 20;
    @(negedge clk);
    reload = 1'b1;
    do begin
      @(negedge clk);
      budget--;
    end while (w_ready !== 1'b1 && budget > 0);
    reload = 1'b0;
    ok = (w_ready === 1'b1);
  endtask

  task automatic frame_1_to_9(input int reps);
    pix_src.delete();
    for (int f = 0; f < reps; f++)
      for (int i = 1; i <= 9; i++) pix_src.push_back(i);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    nvec++; if (w_ready !== 1'b1) begin nfail++; $display("FAIL reset_w_ready got %b need 1", w_ready); end
    nvec++; if (pix_ready !== 1'b0) begin nfail++; $display("FAIL reset_pix_ready got %b need 0", pix_ready); end
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
    nvec++; if (out_data !== '0) begin nfail++; $display("FAIL reset_out_data got %h need 0", out_data); end
    nvec++; if (out_row !== '0 || out_col !== '0) begin nfail++; $display("FAIL reset_coord got %0d,%0d need 0,0", out_row, out_col); end
    nvec++; if (frame_done !== 1'b0) begin nfail++; $display("FAIL reset_frame_done got %b need 0", frame_done); end
    rst = 1'b1;
  endtask

  task automatic test_basic_frame;
    bit ok; logic pr, wr;
    wsrc = '{1, 1, 1, 1, 2, 0, 0, 1};
    load_weights(1'b0, ok, pr, wr);
    nvec++; if (!ok) begin nfail++; $display("FAIL basic_load timed out, got ok=%b need 1", ok); end
    nvec++; if (pr !== 1'b1 || wr !== 1'b0) begin nfail++; $display("FAIL basic_to_stream got pix_ready=%b w_ready=%b need 1,0", pr, wr); end
    obs_q.delete(); exp_q.delete();
    frame_1_to_9(1);
    send(0, -1, -1, ok);
    idle(5);
    nvec++; if (!ok || obs_q.size() != 4) begin nfail++; $display("FAIL basic_count got %0d need 4", obs_q.size()); end
    for (int i = 0; i < 4; i++) if (i < obs_q.size()) begin
      nvec++;
      if (obs_q[i].data[ACC_W-1:0] !== ACC_W'(ref0[i]) || obs_q[i].data[ACC_W +: ACC_W] !== ACC_W'(ref1[i])
          || obs_q[i].row !== RW'(i/2) || obs_q[i].col !== CW'(i%2)) begin
        nfail++;
        $display("FAIL basic_const%0d got (%0d,%0d)@(%0d,%0d) need (%0d,%0d)@(%0d,%0d)", i,
                 obs_q[i].data[ACC_W-1:0], obs_q[i].data[ACC_W +: ACC_W], obs_q[i].row, obs_q[i].col,
                 ref0[i], ref1[i], i/2, i%2);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL basic_out%0d got %h need %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bubbles;
    bit ok;
    obs_q.delete(); exp_q.delete();
    frame_1_to_9(1);
    send(1, -1, -1, ok);
    idle(5);
    nvec++; if (!ok || obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL bubbles_count got %0d need %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL bubbles_out%0d got %h need %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok; int fds;
    obs_q.delete(); exp_q.delete();
    frame_1_to_9(2);
    send(0, -1, -1, ok);
    idle(5);
    fds = 0;
    foreach (obs_q[i]) if (obs_q[i].fd) fds++;
    nvec++; if (!ok || obs_q.size() != 8) begin nfail++; $display("FAIL b2b_count got %0d need 8", obs_q.size()); end
    nvec++; if (fds != 2) begin nfail++; $display("FAIL b2b_frame_done got %0d need 2", fds); end
    for (int i = 0; i < 4 && i + 4 < obs_q.size(); i++) begin
      nvec++; if (obs_q[i+4].data !== obs_q[i].data) begin nfail++; $display("FAIL b2b_repeat%0d got %h need %h", i, obs_q[i+4].data, obs_q[i].data); end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL b2b_out%0d got %h need %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reload_hold;
    bit ok;
    obs_q.delete(); exp_q.delete();
    frame_1_to_9(1);
    send(0, 1, 8, ok);
    idle(5);
    nvec++; if (!ok || obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL hold_count got %0d need %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL hold_out%0d got %h need %h", i, obs_q[i], exp_q[i]); end
    end
    nvec++; if (pix_ready !== 1'b1 || w_ready !== 1'b0) begin nfail++; $display("FAIL hold_state got pix_ready=%b w_ready=%b need 1,0", pix_ready, w_ready); end
  endtask

  task automatic test_reload_new_weights;
    bit ok; logic pr, wr;
    int n0[4]; int n1[4];
    n0 = '{5, 6, 8, 9};
    n1 = '{1, 2, 4, 5};
    @(negedge clk);
    reload = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'd77;
    @(negedge clk);
    reload = 1'b0;
    #1;
    nvec++; if (w_ready !== 1'b1 || pix_ready !== 1'b0) begin nfail++; $display("FAIL reload_to_load got w_ready=%b pix_ready=%b need 1,0", w_ready, pix_ready); end
    wsrc = '{0, 0, 0, 1, 1, 0, 0, 0};
    load_weights(1'b1, ok, pr, wr);
    pix_valid = 1'b0;
    nvec++; if (!ok || pr !== 1'b1) begin nfail++; $display("FAIL reload_load got ok=%b pix_ready=%b need 1,1", ok, pr); end
    obs_q.delete(); exp_q.delete();
    frame_1_to_9(1);
    send(0, -1, -1, ok);
    idle(5);
    nvec++; if (!ok || obs_q.size() != 4) begin nfail++; $display("FAIL reload_count got %0d need 4", obs_q.size()); end
    for (int i = 0; i < 4; i++) if (i < obs_q.size()) begin
      nvec++;
      if (obs_q[i].data[ACC_W-1:0] !== ACC_W'(n0[i]) || obs_q[i].data[ACC_W +: ACC_W] !== ACC_W'(n1[i])) begin
        nfail++;
        $display("FAIL reload_const%0d got (%0d,%0d) need (%0d,%0d)", i, obs_q[i].data[ACC_W-1:0],
                 obs_q[i].data[ACC_W +: ACC_W], n0[i], n1[i]);
      end
    end
  endtask

  task automatic test_max_values;
    bit ok; logic pr, wr;
    request_reload(ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL max_reload got w_ready=%b need 1", w_ready); end
    foreach (wsrc[i]) wsrc[i] = 255;
    load_weights(1'b0, ok, pr, wr);
    obs_q.delete(); exp_q.delete();
    pix_src.delete();
    for (int i = 0; i < 9; i++) pix_src.push_back(255);
    send(0, -1, -1, ok);
    idle(5);
    nvec++; if (!ok || obs_q.size() != 4) begin nfail++; $display("FAIL max_count got %0d need 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++)
      for (int k = 0; k < NK; k++) begin
        nvec++;
        if (obs_q[i].data[k*ACC_W +: ACC_W] !== ACC_W'(260100)) begin
          nfail++; $display("FAIL max_out%0d_k%0d got %0d need 260100", i, k, obs_q[i].data[k*ACC_W +: ACC_W]);
        end
      end
  endtask

  task automatic test_random;
    bit ok; logic pr, wr;
    request_reload(ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL rand_reload got w_ready=%b need 1", w_ready); end
    foreach (wsrc[i]) wsrc[i] = $urandom_range(0, 255);
    load_weights(1'b1, ok, pr, wr);
    obs_q.delete(); exp_q.delete();
    pix_src.delete();
    for (int i = 0; i < 3*IMG_W*IMG_H; i++) pix_src.push_back($urandom_range(0, 255));
    send(2, -1, -1, ok);
    idle(5);
    nvec++; if (!ok || obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL rand_count got %0d need %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      nvec++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL rand_out%0d got %h need %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok; logic pr, wr;
    obs_q.delete(); exp_q.delete();
    pix_src.delete();
    for (int i = 1; i <= 5; i++) pix_src.push_back(i);
    send(0, -1, -1, ok);
    @(negedge clk);
    pix_valid = 1'b0;
    rst = 1'b0;
    #1;
    obs_q.delete(); exp_q.delete();
    nvec++; if (out_valid !== 1'b0 || out_data !== '0) begin nfail++; $display("FAIL midrst_outputs got v=%b d=%h need 0,0", out_valid, out_data); end
    repeat (4) @(negedge clk);
    nvec++; if (obs_q.size() != 0) begin nfail++; $display("FAIL midrst_no_valid got %0d outputs need 0", obs_q.size()); end
    nvec++; if (w_ready !== 1'b1) begin nfail++; $display("FAIL midrst_load got w_ready=%b need 1", w_ready); end
    rst = 1'b1;
    mrow = 0;
    mcol = 0;
    wsrc = '{1, 1, 1, 1, 2, 0, 0, 1};
    load_weights(1'b0, ok, pr, wr);
    obs_q.delete(); exp_q.delete();
    frame_1_to_9(1);
    send(0, -1, -1, ok);
    idle(5);
    nvec++; if (!ok || obs_q.size() != 4) begin nfail++; $display("FAIL midrst_count got %0d need 4", obs_q.size()); end
    for (int i = 0; i < 4; i++) if (i < obs_q.size()) begin
      nvec++;
      if (obs_q[i].data[ACC_W-1:0] !== ACC_W'(ref0[i]) || obs_q[i].data[ACC_W +: ACC_W] !== ACC_W'(ref1[i])) begin
        nfail++;
        $display("FAIL midrst_const%0d got (%0d,%0d) need (%0d,%0d)", i, obs_q[i].data[ACC_W-1:0],
                 obs_q[i].data[ACC_W +: ACC_W], ref0[i], ref1[i]);
      end
    end
  endtask

  initial begin
    ref0 = '{12, 16, 24, 28};
    ref1 = '{7, 10, 16, 19};
    test_reset();
    test_basic_frame();
    test_bubbles();
    test_back_to_back();
    test_reload_hold();
    test_reload_new_weights();
    test_max_values();
    test_random();
    test_reset_mid_frame();
    nvec++; if (stray_fd != 0) begin nfail++; $display("FAIL stray_frame_done got %0d need 0", stray_fd); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/conv_stream_multi_k.md
# conv_stream_multi_k

Parametrised streaming KxK convolution datapath producing NUM_K kernel results per window. Successor to the fixed 2x2 convolution core:
- kernel size, kernel count and image geometry are generic;
- weights are loaded serially under handshake;
- raster pixels are accepted under valid/ready;
- each output carries its window coordinates and frame framing.

It sits between the pixel source and the result collector; a control FSM only drives `reload`.

## Interface
Parameters:
- `DATA_W`, default 8: pixel and weight width, unsigned.
- `IMG_WIDTH`, default 3: pixels per row, must be ≥ KSIZE.
- `IMG_HEIGHT`, default 3: rows per frame, must be ≥ KSIZE.
- `KSIZE`, default 2: kernel edge; window is KSIZE x KSIZE.
- `NUM_K`, default 2: number of kernels evaluated in parallel.
- Derived `ACC_W` = 2*DATA_W + $clog2(KSIZE*KSIZE) (18 at defaults).

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `w_valid` in 1: weight word valid.
- `w_data` in DATA_W: weight word.
- `w_ready` out 1: high only in LOAD.
- `reload` in 1: request return to LOAD (see Operation).
- `pix_valid` in 1: pixel valid.
- `pix_data` in DATA_W: raster-order pixel.
- `pix_ready` out 1: high only in STREAM.
- `out_valid` out 1: result word valid, one-cycle pulse per window.
- `out_data` out NUM_K*ACC_W: kernel k result in bits [k*ACC_W +: ACC_W].
- `out_row` out $clog2(IMG_HEIGHT): window top row.
- `out_col` out $clog2(IMG_WIDTH): window left column.
- `frame_done` out 1: pulses with the last out_valid of a frame.

## Operation
- **FSM states:** LOAD (reset state) and STREAM.
- **LOAD**
  - Each w_valid&&w_ready edge writes w_data to weight slot s, then increments s.
  - Slot order: s = k*KSIZE*KSIZE + t, where tap t = r*KSIZE + c; r=0 is the top row, c=0 the left column.
  - After slot NUM_K*KSIZE*KSIZE-1 is written: s clears, FSM moves to STREAM on that same edge.
  - pix_valid is ignored in LOAD.
- **STREAM**
  - Each pix_valid&&pix_ready edge shifts the pixel into KSIZE-1 line buffers of IMG_WIDTH entries plus a KSIZE x KSIZE window register.
  - Each such edge also advances col; on col wrap it advances row.
  - At the last pixel of a frame, row and col wrap to 0. The next frame follows back-to-back with the same weights; no flush is needed.
  - w_valid is ignored in STREAM.
- **Window valid:** the accepted pixel is at (row ≥ KSIZE-1, col ≥ KSIZE-1). Exactly (IMG_HEIGHT-KSIZE+1)*(IMG_WIDTH-KSIZE+1) windows per frame.
  - Stale line-buffer contents from the previous frame feed only invalid windows.
- **Arithmetic**
  - Result k = sum over t of w[k][t]*pix(top+r, left+c), all unsigned.
  - Products are 2*DATA_W bits; the sum is ACC_W bits and never overflows.
- **Pipeline:** stage 1 registers all NUM_K*KSIZE² products plus coordinates and a valid bit. Stage 2 registers the sums onto out_data.
- **Reload**
  - Honoured in STREAM only when row=col=0 and both pipeline stages are empty. FSM then moves to LOAD and s=0.
  - Otherwise reload is ignored; it is not latched.
  - Weights in use are never modified outside LOAD.

## Timing
- **Reset values:** state=LOAD, s=0, row=col=0, w_ready=1, pix_ready=0, out_valid=0, out_data=0, out_row=0, out_col=0, frame_done=0, pipeline valid bits 0.
  - Weight registers and line buffers are also cleared.
- **Reset mid-frame:** all in-flight windows are discarded; no out_valid occurs after reset assertion. Weights must be reloaded.
- **Latency:** pixel accepted at edge n completing a window gives out_valid high for exactly the cycle after edge n+2.
- **Throughput:** one window per accepted pixel. Gaps on pix_valid create matching gaps on out_valid, with no other effect.
- **Outputs:** out_data, out_row and out_col hold their last value when out_valid=0. There is no output backpressure.
- **frame_done:** high in the same cycle as the out_valid for window (IMG_HEIGHT-KSIZE, IMG_WIDTH-KSIZE).
- **FSM transitions:**
  - LOAD→STREAM: pix_ready rises in the cycle after the final weight edge.
  - STREAM→LOAD: w_ready rises in the cycle after reload is honoured.

## Test plan
- **Basic frame (defaults):** weights 1,1,1,1 then 2,0,0,1; pixels 1..9.
  - Required: 4 outputs (k0,k1) = (12,7), (16,10), (24,16), (28,19) at (row,col) (0,0),(0,1),(1,0),(1,1).
  - frame_done with the last output; each output 2 cycles after its pixel.
- **Bubbles:** same data with pix_valid deasserted every other cycle → identical results; each output still 2 cycles after its completing pixel.
- **Max values:** all weights and pixels 255, defaults → every result 260100, no wrap.
- **Back-to-back frames:** 18 pixels with no gap → 8 outputs and 2 frame_done pulses; second-frame results equal the first.
- **Reload rules**
  - reload held high mid-frame → ignored; frame completes with the same results.
  - reload after the last output → LOAD. Pixels offered in LOAD are not accepted.
  - New weights 0,0,0,1 / 1,0,0,0 → outputs (5,1),(6,2),(8,4),(9,5).
- **Reset mid-frame:** assert rst after pixel 5 → outputs zero immediately and no out_valid. After reload, a full frame gives the basic-frame results.
